// File: rtl/matinv_seq.sv
// matinv_seq: sequential Gauss-Jordan fixed-point matrix inverter with partial pivoting.
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, aborts any run
//   start    run request, accepted only while idle
//   matrix   N*N elements, element (r,c) at [(r*N+c)*DATA_WIDTH +: DATA_WIDTH], sampled in LOAD
//   busy     high from the cycle after an accepted start through the done cycle
//   done     one-cycle pulse, inv/singular valid from this cycle
//   singular zero pivot met (or, with saturation, any narrowing clipped); held until next start
//   inv      result, same packing as matrix; held until next start
//   Define MATINV_SAT_EN to saturate every narrowing instead of wrapping.
module matinv_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int BIN_POS     = 16,
    parameter int MATRIX_SIZE = 3
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] matrix,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          singular,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] inv
);
    localparam int N  = MATRIX_SIZE;
    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int KW = $clog2(MATRIX_SIZE);
`ifdef MATINV_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_PIVOT = 3'd2;
    localparam logic [2:0] S_RECIP = 3'd3;
    localparam logic [2:0] S_NORM  = 3'd4;
    localparam logic [2:0] S_ELIM  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic signed [DW-1:0] ONE    = DW'(1) <<< BIN_POS;
    localparam logic signed [PW-1:0] ONE_SQ = PW'(1) <<< (2 * BIN_POS);

    function automatic logic signed [PW-1:0] sext(input logic signed [DW-1:0] a);
        return $signed({{DW{a[DW-1]}}, a});
    endfunction

    // Q-format product: full-width multiply, then floor shift back to BIN_POS fraction bits
    function automatic logic signed [PW-1:0] mul(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
        logic signed [PW-1:0] p;
        p = sext(a) * sext(b);
        return p >>> BIN_POS;
    endfunction

    // returns {clipped, value}; clipped can only be set when saturation is enabled
    function automatic logic [DW:0] narrow(input logic signed [PW-1:0] x);
        logic ovf;
        ovf = x != {{(PW-DW){x[DW-1]}}, x[DW-1:0]};
        return (SAT_EN && ovf) ? {1'b1, x[PW-1], {(DW-1){~x[PW-1]}}} : {1'b0, x[DW-1:0]};
    endfunction

    // one extra bit so the most negative value has a representable magnitude
    function automatic logic [DW:0] mag(input logic signed [DW-1:0] a);
        logic [DW:0] e;
        e = {a[DW-1], a};
        return a[DW-1] ? -e : e;
    endfunction

    logic [2:0]           state_q, state_d;
    logic [KW-1:0]        k_q, k_d, i_q, i_d, bp;
    logic signed [DW-1:0] r_q, r_d;
    logic                 sat_q, sat_d, sing_q, sing_d;
    logic [N*N*DW-1:0]    inv_q, inv_d;
    logic signed [DW-1:0] a_q [N][2*N];
    logic signed [DW-1:0] a_d [N][2*N];
    logic [DW:0]          best, nv;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        i_d     = i_q;
        r_d     = r_q;
        sat_d   = sat_q;
        sing_d  = sing_q;
        inv_d   = inv_q;
        a_d     = a_q;
        best    = '0;
        bp      = k_q;
        nv      = '0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_LOAD;
                k_d     = '0;
                i_d     = '0;
                sat_d   = 1'b0;
                sing_d  = 1'b0;
                inv_d   = '0;
            end
            S_LOAD: begin
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++) begin
                        a_d[r][c]   = matrix[(r*N+c)*DW +: DW];
                        a_d[r][N+c] = (r == c) ? ONE : '0;
                    end
                state_d = S_PIVOT;
            end
            S_PIVOT: begin
                // strict > keeps the lowest row index on magnitude ties
                for (int p = 0; p < N; p++)
                    if (KW'(p) >= k_q && mag(a_q[p][k_q]) > best) begin
                        best = mag(a_q[p][k_q]);
                        bp   = KW'(p);
                    end
                if (best == '0) begin
                    state_d = S_DONE;
                    sing_d  = 1'b1;
                    inv_d   = '0;
                end else begin
                    for (int j = 0; j < 2*N; j++) begin
                        a_d[k_q][j] = a_q[bp][j];
                        a_d[bp][j]  = a_q[k_q][j];
                    end
                    state_d = S_RECIP;
                end
            end
            S_RECIP: begin
                nv      = narrow(ONE_SQ / sext(a_q[k_q][k_q]));
                r_d     = nv[DW-1:0];
                sat_d   = sat_q | nv[DW];
                state_d = S_NORM;
            end
            S_NORM: begin
                for (int j = 0; j < 2*N; j++) begin
                    nv          = narrow(mul(a_q[k_q][j], r_q));
                    a_d[k_q][j] = nv[DW-1:0];
                    sat_d       = sat_d | nv[DW];
                end
                i_d     = '0;
                state_d = S_ELIM;
            end
            S_ELIM: begin
                if (i_q != k_q)
                    for (int j = 0; j < 2*N; j++) begin
                        nv          = narrow(sext(a_q[i_q][j]) - mul(a_q[i_q][k_q], a_q[k_q][j]));
                        a_d[i_q][j] = nv[DW-1:0];
                        sat_d       = sat_d | nv[DW];
                    end
                if (i_q == KW'(N-1)) begin
                    i_d = '0;
                    if (k_q == KW'(N-1)) begin
                        state_d = S_DONE;
                        sing_d  = sat_d;
                        for (int r = 0; r < N; r++)
                            for (int c = 0; c < N; c++)
                                inv_d[(r*N+c)*DW +: DW] = a_d[r][N+c];
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = S_PIVOT;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            i_q     <= '0;
            r_q     <= '0;
            sat_q   <= 1'b0;
            sing_q  <= 1'b0;
            inv_q   <= '0;
            a_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            r_q     <= r_d;
            sat_q   <= sat_d;
            sing_q  <= sing_d;
            inv_q   <= inv_d;
            a_q     <= a_d;
        end
    end

    assign busy     = state_q != S_IDLE;
    assign done     = state_q == S_DONE;
    assign singular = sing_q;
    assign inv      = inv_q;
endmodule

// File: tb/tb_matinv_seq.sv
// tb_matinv_seq: directed bench for matinv_seq (N=3, Q16.16) with hand-computed results.
module tb_matinv_seq;
    localparam int N  = 3;
    localparam int DW = 32;
    localparam logic [31:0] O = 32'h0001_0000;
    localparam logic [31:0] Z = 32'h0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [N*N*DW-1:0] matrix = '0;
    logic              busy, done, singular;
    logic [N*N*DW-1:0] inv;
    int                n_chk = 0;
    int                n_fail = 0;
    int                lat;
    logic [31:0]       mv [9];
    logic [31:0]       ev [9];

    matinv_seq #(.DATA_WIDTH(32), .BIN_POS(16), .MATRIX_SIZE(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .matrix(matrix),
        .busy(busy), .done(done), .singular(singular), .inv(inv)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_mat();
        for (int i = 0; i < 9; i++) matrix[i*DW +: DW] = mv[i];
    endtask

    task automatic check_inv(input string tag);
        for (int i = 0; i < 9; i++)
            check($sformatf("%s inv[%0d]", tag, i), 64'(inv[i*DW +: DW]), 64'(ev[i]));
    endtask

    // starts a run from idle, optionally pulses start at edge count pulse_at, returns edges to done
    task automatic run_op(input int pulse_at, output int n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy after accept", 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 60) begin
            start = (pulse_at != 0 && n == pulse_at);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("done within budget", 64'(done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset singular", 64'(singular), 64'd0);
        check("reset inv zero", 64'(inv != '0), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        mv = '{O, Z, Z, Z, O, Z, Z, Z, O};
        ev = mv;
        load_mat();
        run_op(0, lat);
        check("identity latency", 64'(lat), 64'd19);
        check("identity singular", 64'(singular), 64'd0);
        check_inv("identity");
        @(posedge clk); #1;
        check("identity busy after done", 64'(busy), 64'd0);
        check("identity done pulse", 64'(done), 64'd0);

        mv = '{32'h0002_0000, Z, Z, Z, 32'h0004_0000, Z, Z, Z, 32'hFFF8_0000};
        ev = '{32'h0000_8000, Z, Z, Z, 32'h0000_4000, Z, Z, Z, 32'hFFFF_E000};
        load_mat();
        run_op(0, lat);
        check("diag latency", 64'(lat), 64'd19);
        check("diag singular", 64'(singular), 64'd0);
        check_inv("diag");
        @(posedge clk); #1;

        mv = '{Z, O, Z, O, Z, Z, Z, Z, O};
        ev = mv;
        load_mat();
        run_op(0, lat);
        check("perm singular", 64'(singular), 64'd0);
        check_inv("perm");
        @(posedge clk); #1;

        mv = '{O, O, Z, Z, O, Z, Z, Z, O};
        ev = '{O, 32'hFFFF_0000, Z, Z, O, Z, Z, Z, O};
        load_mat();
        run_op(0, lat);
        check("upper singular", 64'(singular), 64'd0);
        check_inv("upper");
        @(posedge clk); #1;

        mv = '{O, Z, Z, 32'hFFFE_0000, O, Z, Z, Z, O};
        ev = '{O, Z, Z, 32'h0002_0000, O, Z, Z, Z, O};
        load_mat();
        run_op(0, lat);
        check("negpivot latency", 64'(lat), 64'd19);
        check("negpivot singular", 64'(singular), 64'd0);
        check_inv("negpivot");
        @(posedge clk); #1;

        mv = '{O, O, O, O, O, O, O, O, O};
        ev = '{Z, Z, Z, Z, Z, Z, Z, Z, Z};
        load_mat();
        run_op(0, lat);
        check("ones latency", 64'(lat), 64'd8);
        check("ones singular", 64'(singular), 64'd1);
        check_inv("ones");
        @(posedge clk); #1;
        check("ones busy after done", 64'(busy), 64'd0);

        mv = '{32'h0002_0000, Z, Z, Z, 32'h0004_0000, Z, Z, Z, 32'hFFF8_0000};
        ev = '{32'h0000_8000, Z, Z, Z, 32'h0000_4000, Z, Z, Z, 32'hFFFF_E000};
        load_mat();
        run_op(5, lat);
        check("midrun start latency", 64'(lat), 64'd19);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start at done ignored", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("still idle", 64'(busy), 64'd0);
        check_inv("midrun");

        mv = '{Z, O, Z, O, Z, Z, Z, Z, O};
        load_mat();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort singular", 64'(singular), 64'd0);
        check("abort inv zero", 64'(inv != '0), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mv = '{O, O, Z, Z, O, Z, Z, Z, O};
        ev = '{O, 32'hFFFF_0000, Z, Z, O, Z, Z, Z, O};
        load_mat();
        run_op(0, lat);
        check("after abort latency", 64'(lat), 64'd19);
        check_inv("after abort");
        @(posedge clk); #1;

        mv = '{32'h0000_0001, Z, Z, Z, O, Z, Z, Z, O};
`ifdef MATINV_SAT_EN
        ev = '{32'h7FFF_FFFF, Z, Z, Z, O, Z, Z, Z, O};
`else
        ev = '{Z, Z, Z, Z, O, Z, Z, Z, O};
`endif
        load_mat();
        run_op(0, lat);
`ifdef MATINV_SAT_EN
        check("tiny pivot singular", 64'(singular), 64'd1);
`else
        check("tiny pivot singular", 64'(singular), 64'd0);
`endif
        check_inv("tiny pivot");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
